// File: rtl/uart_rx_eor.sv
// 8N1 UART receiver with an end-of-reception flag for the terminal control FSM.
// eor_o is low only between a validated start bit and the mid-point of the stop bit.
module uart_rx_eor #(
    parameter int DIV   = 434,
    parameter int CNT_W = 9
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       eor_o,
    output logic       ferr_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             eor_q, eor_d;
    logic             ferr_q, ferr_d;
    logic             rx_s;

    assign rx_s = sync2_q;

    // Two-flop synchroniser; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            eor_q   <= 1'b1;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            eor_q   <= eor_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        eor_d   = eor_q;
        ferr_d  = ferr_q;

        case (state_q)
            S_IDLE: begin
                eor_d = 1'b1;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                // A start bit that is high again at mid-bit was a glitch: no eor_o pulse.
                if (cnt_q == HALF_M1) begin
                    if (!rx_s) begin
                        state_d = S_DATA;
                        eor_d   = 1'b0;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end

            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    data_d  = shift_q;
                    eor_d   = 1'b1;
                    ferr_d  = ~rx_s;
                    state_d = rx_s ? S_IDLE : S_BREAK;
                end
            end

            S_BREAK: begin
                // Hold off until the line returns high so a break cannot re-trigger frames.
                eor_d = 1'b1;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                eor_d   = 1'b1;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    assign data_o = data_q;
    assign eor_o  = eor_q;
    assign ferr_o = ferr_q;

endmodule

// File: tb/tb_uart_rx_eor.sv
// Bench for uart_rx_eor at DIV = 16: a line driver pushes {ferr, data} per frame,
// and a monitor pops and compares on each eor_o rise, also timing the eor_o pulse.
module tb_uart_rx_eor;

    localparam int DIV   = 16;
    localparam int CNT_W = 5;
    localparam int W     = 9;
    // rx_i drive -> two synchroniser flops -> IDLE detect edge -> DIV/2 in START
    localparam int FALL_LAT = 3 + DIV / 2;
    localparam int LOW_TIME = 9 * DIV;

    logic       clk_i;
    logic       rst_i;
    logic       rx_i;
    logic [7:0] data_o;
    logic       eor_o;
    logic       ferr_o;

    logic [W-1:0] exp_q[$];
    int n_checks;
    int n_errors;
    int cyc;
    int start_cyc;
    int fall_cyc;
    int falls;
    int falls_mark;
    logic prev_eor;

    uart_rx_eor #(.DIV(DIV), .CNT_W(CNT_W)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .rx_i   (rx_i),
        .data_o (data_o),
        .eor_o  (eor_o),
        .ferr_o (ferr_o)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // driver tasks
    task automatic drive_bit(input logic b);
        rx_i = b;
        repeat (DIV) @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        exp_q.push_back({~stop, d});
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        rx_i = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 4000;
        while ((exp_q.size() != 0 || eor_o !== 1'b1) && budget > 0) begin
            @(posedge clk_i);
            budget--;
        end
        #1;
        check("drain", exp_q.size(), 0);
        idle_cycles(10);
    endtask

    // scoreboard / monitor
    initial begin
        prev_eor = 1'b1;
        falls    = 0;
        fall_cyc = 0;
    end

    always @(negedge clk_i) begin
        logic [W-1:0] e;
        if (rst_i) begin
            prev_eor = eor_o;
        end else begin
            if (prev_eor === 1'b1 && eor_o === 1'b0) begin
                falls++;
                fall_cyc = cyc;
                check("fall_latency", cyc - start_cyc, FALL_LAT);
            end else if (prev_eor === 1'b0 && eor_o === 1'b1) begin
                check("low_time", cyc - fall_cyc, LOW_TIME);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("frame", {ferr_o, data_o}, e);
                end
            end
            prev_eor = eor_o;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] b2b [3];
        n_checks  = 0;
        n_errors  = 0;
        start_cyc = 0;
        rst_i     = 1'b1;
        rx_i      = 1'b1;
        b2b[0] = 8'h55;
        b2b[1] = 8'hAA;
        b2b[2] = 8'hFF;

        // 1: reset values, then a quiet idle line
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_eor", eor_o, 1);
        check("rst_data", data_o, 8'h00);
        check("rst_ferr", ferr_o, 0);
        rst_i = 1'b0;
        idle_cycles(500);
        check("idle_eor", eor_o, 1);
        check("idle_data", data_o, 8'h00);
        check("idle_ferr", ferr_o, 0);
        check("idle_falls", falls, 0);

        // 2: single frame 'A'
        send_frame(8'h41, 1'b1);
        wait_idle();
        check("a_data", data_o, 8'h41);
        check("a_ferr", ferr_o, 0);
        check("a_falls", falls, 1);

        // 3: 4-cycle glitch must not start a frame
        falls_mark = falls;
        rx_i = 1'b0;
        idle_cycles(4);
        rx_i = 1'b1;
        idle_cycles(3 * DIV);
        check("glitch_falls", falls, falls_mark);
        check("glitch_eor", eor_o, 1);
        check("glitch_data", data_o, 8'h41);

        // 4: framing error followed by a held-low break, then recovery
        falls_mark = falls;
        send_frame(8'h5A, 1'b0);
        rx_i = 1'b0;
        idle_cycles(100);
        check("brk_data", data_o, 8'h5A);
        check("brk_ferr", ferr_o, 1);
        check("brk_eor", eor_o, 1);
        check("brk_falls", falls, falls_mark + 1);
        rx_i = 1'b1;
        idle_cycles(2 * DIV);
        check("brk_quiet", falls, falls_mark + 1);
        send_frame(8'h0D, 1'b1);
        wait_idle();
        check("cr_data", data_o, 8'h0D);
        check("cr_ferr", ferr_o, 0);

        // 5: back-to-back frames with no idle gap
        falls_mark = falls;
        foreach (b2b[i]) send_frame(b2b[i], 1'b1);
        wait_idle();
        check("b2b_falls", falls, falls_mark + 3);
        check("b2b_ferr", ferr_o, 0);

        // 6: reset in the middle of bit 4 of 0x33 (bits LSB first: 1 1 0 0 1 1 0 0)
        start_cyc = cyc;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rx_i = 1'b1;
        idle_cycles(8);
        rst_i = 1'b1;
        #1;
        check("midrst_eor", eor_o, 1);
        check("midrst_data", data_o, 8'h00);
        check("midrst_ferr", ferr_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle_cycles(7);
        drive_bit(1'b1);
        // Bit 6 (0) now looks like a start; bit 7 (0) becomes data bit 0, the rest reads as 1s.
        exp_q.push_back({1'b0, 8'hFE});
        start_cyc = cyc;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        wait_idle();
        send_frame(8'h31, 1'b1);
        wait_idle();
        check("post_rst_data", data_o, 8'h31);
        check("post_rst_ferr", ferr_o, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
